plugin_collector: RTL and testbench

PLUGIN_COLLECTOR -- requirements
Module: plugin_collector

---
 rtl/iso16_pkg.sv | 18 +
 rtl/iso16_sat_accum.sv | 51 +++++
 rtl/plugin_collector.sv | 166 ++++++++++++++++
 tb/tb_plugin_collector.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/iso16_pkg.sv
// Shared definitions for the plugin collector: default widths, accumulator
// guard bits and the collector FSM state encoding.
package iso16_pkg;

    localparam int unsigned WARP_WIDTH_DEF  = 16;
    localparam int unsigned ERROR_WIDTH_DEF = 32;
    localparam int unsigned WARP_GUARD      = 5;
    localparam int unsigned ERROR_GUARD     = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_COLLECT = 3'd2,
        ST_ACCUM   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/iso16_sat_accum.sv
// Guard-bit accumulator with a saturated view of the value it is about to hold,
// so the owner can latch the final sum on the same edge as the last add.
module iso16_sat_accum #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned GUARD  = 5,
    parameter bit          SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             add_en,
    input  logic [WIDTH-1:0] addend,
    output logic [WIDTH-1:0] sat_c
);

    localparam int unsigned AW = WIDTH + GUARD;

    logic [AW-1:0]    acc_q;
    logic [AW-1:0]    ext_c;
    logic [AW-1:0]    next_c;
    logic [GUARD:0]   upper_c;

    always_comb begin
        ext_c   = SIGNED ? {{GUARD{addend[WIDTH-1]}}, addend} : {{GUARD{1'b0}}, addend};
        next_c  = acc_q + (add_en ? ext_c : '0);
        upper_c = next_c[AW-1:WIDTH-1];
    end

    // Signed: in range when the guard bits all match the result sign bit.
    always_comb begin
        sat_c = next_c[WIDTH-1:0];
        if (SIGNED) begin
            if (!((&upper_c) || (~|upper_c))) begin
                sat_c = next_c[AW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else if (|next_c[AW-1:WIDTH]) begin
            sat_c = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (add_en) begin
            acc_q <= next_c;
        end
    end

endmodule

// File: rtl/plugin_collector.sv
// Broadcasts a start to all plugins, waits a fixed window, then walks the
// plugins one per cycle summing warp/error terms into saturated results.
module plugin_collector
    import iso16_pkg::*;
#(
    parameter int unsigned WARP_WIDTH     = WARP_WIDTH_DEF,
    parameter int unsigned ERROR_WIDTH    = ERROR_WIDTH_DEF,
    parameter int unsigned NUM_PLUGINS    = 2,
    parameter int unsigned COLLECT_CYCLES = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cycle_req,
    output logic                              busy,
    output logic                              plugin_start,
    input  logic [NUM_PLUGINS-1:0]            plugin_valid,
    input  logic [NUM_PLUGINS*WARP_WIDTH-1:0] plugin_warp_x,
    input  logic [NUM_PLUGINS*WARP_WIDTH-1:0] plugin_warp_y,
    input  logic [NUM_PLUGINS*WARP_WIDTH-1:0] plugin_warp_z,
    input  logic [NUM_PLUGINS*ERROR_WIDTH-1:0] plugin_error,
    output logic                              result_valid,
    output logic [WARP_WIDTH-1:0]             warp_sum_x,
    output logic [WARP_WIDTH-1:0]             warp_sum_y,
    output logic [WARP_WIDTH-1:0]             warp_sum_z,
    output logic [ERROR_WIDTH-1:0]            error_sum,
    output logic [NUM_PLUGINS-1:0]            valid_mask,
    output logic                              timeout
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDX_W = 5;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         win_q, win_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [NUM_PLUGINS-1:0]   mask_q, mask_d;
    logic [WARP_WIDTH-1:0]    sum_x_d, sum_y_d, sum_z_d;
    logic [ERROR_WIDTH-1:0]   err_d;
    logic [NUM_PLUGINS-1:0]   vmask_d;
    logic                     timeout_d;
    logic                     clear_c;
    logic                     add_c;

    logic [WARP_WIDTH-1:0]    sel_x_c, sel_y_c, sel_z_c;
    logic [ERROR_WIDTH-1:0]   sel_err_c;
    logic                     sel_valid_c;
    logic [WARP_WIDTH-1:0]    sat_x_c, sat_y_c, sat_z_c;
    logic [ERROR_WIDTH-1:0]   sat_err_c;

    // Route the plugin addressed by idx_q onto the shared accumulator inputs.
    always_comb begin
        sel_x_c     = '0;
        sel_y_c     = '0;
        sel_z_c     = '0;
        sel_err_c   = '0;
        sel_valid_c = 1'b0;
        for (int i = 0; i < NUM_PLUGINS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_x_c     = plugin_warp_x[i*WARP_WIDTH +: WARP_WIDTH];
                sel_y_c     = plugin_warp_y[i*WARP_WIDTH +: WARP_WIDTH];
                sel_z_c     = plugin_warp_z[i*WARP_WIDTH +: WARP_WIDTH];
                sel_err_c   = plugin_error[i*ERROR_WIDTH +: ERROR_WIDTH];
                sel_valid_c = mask_q[i];
            end
        end
    end

    always_comb add_c = (state_q == ST_ACCUM) && sel_valid_c;

    iso16_sat_accum #(.WIDTH(WARP_WIDTH), .GUARD(WARP_GUARD), .SIGNED(1'b1)) u_acc_x (
        .clk(clk), .rst_n(rst_n), .clear(clear_c), .add_en(add_c), .addend(sel_x_c), .sat_c(sat_x_c));
    iso16_sat_accum #(.WIDTH(WARP_WIDTH), .GUARD(WARP_GUARD), .SIGNED(1'b1)) u_acc_y (
        .clk(clk), .rst_n(rst_n), .clear(clear_c), .add_en(add_c), .addend(sel_y_c), .sat_c(sat_y_c));
    iso16_sat_accum #(.WIDTH(WARP_WIDTH), .GUARD(WARP_GUARD), .SIGNED(1'b1)) u_acc_z (
        .clk(clk), .rst_n(rst_n), .clear(clear_c), .add_en(add_c), .addend(sel_z_c), .sat_c(sat_z_c));
    iso16_sat_accum #(.WIDTH(ERROR_WIDTH), .GUARD(ERROR_GUARD), .SIGNED(1'b0)) u_acc_err (
        .clk(clk), .rst_n(rst_n), .clear(clear_c), .add_en(add_c), .addend(sel_err_c), .sat_c(sat_err_c));

    // Next-state and next-output logic; results change only on entry to DONE.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        idx_d     = idx_q;
        mask_d    = mask_q;
        sum_x_d   = warp_sum_x;
        sum_y_d   = warp_sum_y;
        sum_z_d   = warp_sum_z;
        err_d     = error_sum;
        vmask_d   = valid_mask;
        timeout_d = timeout;
        clear_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cycle_req) state_d = ST_START;
            end
            ST_START: begin
                state_d = ST_COLLECT;
                win_d   = '0;
            end
            ST_COLLECT: begin
                if (win_q == CNT_W'(COLLECT_CYCLES - 1)) begin
                    state_d = ST_ACCUM;
                    win_d   = '0;
                    mask_d  = plugin_valid;
                    clear_c = 1'b1;
                    idx_d   = '0;
                end else begin
                    win_d = win_q + CNT_W'(1);
                end
            end
            ST_ACCUM: begin
                if (idx_q == IDX_W'(NUM_PLUGINS - 1)) begin
                    state_d   = ST_DONE;
                    idx_d     = '0;
                    sum_x_d   = sat_x_c;
                    sum_y_d   = sat_y_c;
                    sum_z_d   = sat_z_c;
                    err_d     = sat_err_c;
                    vmask_d   = mask_q;
                    timeout_d = ~&mask_q;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            win_q        <= '0;
            idx_q        <= '0;
            mask_q       <= '0;
            busy         <= 1'b0;
            plugin_start <= 1'b0;
            result_valid <= 1'b0;
            warp_sum_x   <= '0;
            warp_sum_y   <= '0;
            warp_sum_z   <= '0;
            error_sum    <= '0;
            valid_mask   <= '0;
            timeout      <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            idx_q        <= idx_d;
            mask_q       <= mask_d;
            busy         <= (state_d != ST_IDLE);
            plugin_start <= (state_d == ST_START);
            result_valid <= (state_d == ST_DONE);
            warp_sum_x   <= sum_x_d;
            warp_sum_y   <= sum_y_d;
            warp_sum_z   <= sum_z_d;
            error_sum    <= err_d;
            valid_mask   <= vmask_d;
            timeout      <= timeout_d;
        end
    end

endmodule

// File: tb/tb_plugin_collector.sv
// Directed bench for plugin_collector: default instance plus a minimum-size
// instance (one plugin, one-cycle window).
module tb_plugin_collector;

    logic        clk;
    logic        rst_n;
    logic        cycle_req;
    logic        busy;
    logic        plugin_start;
    logic [1:0]  plugin_valid;
    logic [31:0] plugin_warp_x, plugin_warp_y, plugin_warp_z;
    logic [63:0] plugin_error;
    logic        result_valid;
    logic [15:0] warp_sum_x, warp_sum_y, warp_sum_z;
    logic [31:0] error_sum;
    logic [1:0]  valid_mask;
    logic        timeout;

    logic        min_req, min_busy, min_start, min_valid, min_rv;
    logic [15:0] min_x, min_y, min_z, min_sx, min_sy, min_sz;
    logic [31:0] min_err, min_serr;
    logic        min_mask, min_timeout;

    int passed = 0;
    int total  = 0;
    int starts = 0;
    int rvs    = 0;
    int lat;
    int s0, r0;

    plugin_collector dut (
        .clk(clk), .rst_n(rst_n), .cycle_req(cycle_req), .busy(busy),
        .plugin_start(plugin_start), .plugin_valid(plugin_valid),
        .plugin_warp_x(plugin_warp_x), .plugin_warp_y(plugin_warp_y),
        .plugin_warp_z(plugin_warp_z), .plugin_error(plugin_error),
        .result_valid(result_valid), .warp_sum_x(warp_sum_x),
        .warp_sum_y(warp_sum_y), .warp_sum_z(warp_sum_z),
        .error_sum(error_sum), .valid_mask(valid_mask), .timeout(timeout)
    );

    plugin_collector #(.NUM_PLUGINS(1), .COLLECT_CYCLES(1)) dut_min (
        .clk(clk), .rst_n(rst_n), .cycle_req(min_req), .busy(min_busy),
        .plugin_start(min_start), .plugin_valid(min_valid),
        .plugin_warp_x(min_x), .plugin_warp_y(min_y), .plugin_warp_z(min_z),
        .plugin_error(min_err), .result_valid(min_rv), .warp_sum_x(min_sx),
        .warp_sum_y(min_sy), .warp_sum_z(min_sz), .error_sum(min_serr),
        .valid_mask(min_mask), .timeout(min_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (plugin_start) starts <= starts + 1;
        if (result_valid) rvs <= rvs + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Called #1 after a rising edge. lat is the 1-based cycle of result_valid,
    // START being cycle 1. poke re-requests during START, COLLECT, ACCUM, DONE.
    task automatic run_req(input bit poke, output int n);
        cycle_req = 1'b1;
        @(posedge clk); #1;
        cycle_req = 1'b0;
        n = 1;
        while (!result_valid && n < 40) begin
            if (poke) cycle_req = (n == 1 || n == 3 || n == 10);
            @(posedge clk); #1;
            cycle_req = 1'b0;
            n++;
        end
        if (poke) begin
            cycle_req = 1'b1;
            @(posedge clk); #1;
            cycle_req = 1'b0;
        end
    endtask

    task automatic check_sums(input string tag, input logic [15:0] ex, input logic [15:0] ey,
                              input logic [15:0] ez, input logic [31:0] ee,
                              input logic [1:0] em, input logic et);
        check({tag, "_x"}, 64'(warp_sum_x), 64'(ex));
        check({tag, "_y"}, 64'(warp_sum_y), 64'(ey));
        check({tag, "_z"}, 64'(warp_sum_z), 64'(ez));
        check({tag, "_err"}, 64'(error_sum), 64'(ee));
        check({tag, "_mask"}, 64'(valid_mask), 64'(em));
        check({tag, "_timeout"}, 64'(timeout), 64'(et));
    endtask

    initial begin
        rst_n         = 1'b0;
        cycle_req     = 1'b0;
        plugin_valid  = 2'b11;
        plugin_warp_x = {16'h0010, 16'h0020};
        plugin_warp_y = {16'h0010, 16'hFFF0};
        plugin_warp_z = {16'h0000, 16'h0008};
        plugin_error  = {32'd1, 32'd2};
        min_req       = 1'b0;
        min_valid     = 1'b1;
        min_x         = 16'h0005;
        min_y         = 16'hFFFD;
        min_z         = 16'h0000;
        min_err       = 32'd7;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_start", 64'(plugin_start), 64'd0);
        check("rst_rv", 64'(result_valid), 64'd0);
        check_sums("rst", 16'h0, 16'h0, 16'h0, 32'h0, 2'b00, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Nominal: both plugins valid.
        s0 = starts;
        run_req(1'b0, lat);
        check("nom_latency", 64'(lat), 64'd12);
        check("nom_busy_done", 64'(busy), 64'd1);
        check_sums("nom", 16'h0030, 16'h0000, 16'h0008, 32'd3, 2'b11, 1'b0);
        @(posedge clk); #1;
        check("nom_rv_pulse", 64'(result_valid), 64'd0);
        check("nom_idle_busy", 64'(busy), 64'd0);
        check("nom_hold_x", 64'(warp_sum_x), 64'h0030);
        check("nom_starts", 64'(starts - s0), 64'd1);

        // Missing plugin 1.
        plugin_valid = 2'b01;
        run_req(1'b0, lat);
        check("miss_latency", 64'(lat), 64'd12);
        check_sums("miss", 16'h0020, 16'hFFF0, 16'h0008, 32'd2, 2'b01, 1'b1);
        @(posedge clk); #1;

        // Saturation in both directions.
        plugin_valid  = 2'b11;
        plugin_warp_x = {16'h7000, 16'h7000};
        plugin_warp_y = {16'h9000, 16'h9000};
        plugin_warp_z = {16'hFFFF, 16'h0001};
        plugin_error  = {32'h0000_0020, 32'hFFFF_FFF0};
        run_req(1'b0, lat);
        check("sat_latency", 64'(lat), 64'd12);
        check_sums("sat", 16'h7FFF, 16'h8000, 16'h0000, 32'hFFFF_FFFF, 2'b11, 1'b0);
        @(posedge clk); #1;

        // Requests while busy are dropped.
        plugin_warp_x = {16'h0010, 16'h0020};
        plugin_warp_y = {16'h0010, 16'hFFF0};
        plugin_warp_z = {16'h0000, 16'h0008};
        plugin_error  = {32'd1, 32'd2};
        s0 = starts;
        r0 = rvs;
        run_req(1'b1, lat);
        check("busy_latency", 64'(lat), 64'd12);
        repeat (20) @(posedge clk);
        #1;
        check("busy_starts", 64'(starts - s0), 64'd1);
        check("busy_rvs", 64'(rvs - r0), 64'd1);
        check("busy_idle", 64'(busy), 64'd0);

        // Reset at window cycle 4 (START is cycle 1, window cycle 0 is cycle 2).
        r0 = rvs;
        cycle_req = 1'b1;
        @(posedge clk); #1;
        cycle_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_rv", 64'(result_valid), 64'd0);
        check_sums("mid_rst", 16'h0, 16'h0, 16'h0, 32'h0, 2'b00, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("mid_rst_no_rv", 64'(rvs - r0), 64'd0);
        run_req(1'b0, lat);
        check("post_rst_latency", 64'(lat), 64'd12);
        check_sums("post_rst", 16'h0030, 16'h0000, 16'h0008, 32'd3, 2'b11, 1'b0);
        @(posedge clk); #1;

        // Minimum-size instance.
        min_req = 1'b1;
        @(posedge clk); #1;
        min_req = 1'b0;
        lat = 1;
        while (!min_rv && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("min_latency", 64'(lat), 64'd4);
        check("min_x", 64'(min_sx), 64'h0005);
        check("min_y", 64'(min_sy), 64'hFFFD);
        check("min_err", 64'(min_serr), 64'd7);
        check("min_mask", 64'(min_mask), 64'd1);
        check("min_timeout", 64'(min_timeout), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
